// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle controller: state codes, opcode and
// funct constants, ALU / PC-source / destination encodings, instruction classes.
package cpu_defs;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;

    // I-type ALU group is identified by op[5:3]
    localparam logic [2:0] OP_IALU_HI = 3'b001;

    localparam logic [FUNCT_W-1:0] FUNCT_JR = 6'h08;
    // Shift group is identified by funct[5:3]
    localparam logic [2:0] FUNCT_SHIFT_HI = 3'b000;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_REG    = 2'b11;

    localparam logic [1:0] WREG_RT  = 2'b00;
    localparam logic [1:0] WREG_RD  = 2'b01;
    localparam logic [1:0] WREG_JAL = 2'b10;

    typedef enum logic [3:0] {
        CL_RTYPE,
        CL_JR,
        CL_IALU,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_BNE,
        CL_J,
        CL_JAL,
        CL_NONE
    } iclass_e;

endpackage

// File: rtl/instr_class_decode.sv
// Maps a latched opcode/funct pair to an instruction class and a legal flag.
// Ports: opcode_i/funct_i in; iclass_o, legal_o, shift_o (funct is a shift) out.
module instr_class_decode
    import cpu_defs::*;
(
    input  logic [OP_W-1:0]    opcode_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output iclass_e            iclass_o,
    output logic               legal_o,
    output logic               shift_o
);

    // Class lookup; anything not matched is undecodable
    always_comb begin
        iclass_o = CL_NONE;
        if (opcode_i == OP_RTYPE) begin
            iclass_o = (funct_i == FUNCT_JR) ? CL_JR : CL_RTYPE;
        end else if (opcode_i[5:3] == OP_IALU_HI) begin
            iclass_o = CL_IALU;
        end else begin
            case (opcode_i)
                OP_LW:   iclass_o = CL_LW;
                OP_SW:   iclass_o = CL_SW;
                OP_BEQ:  iclass_o = CL_BEQ;
                OP_BNE:  iclass_o = CL_BNE;
                OP_J:    iclass_o = CL_J;
                OP_JAL:  iclass_o = CL_JAL;
                default: iclass_o = CL_NONE;
            endcase
        end
    end

    assign legal_o = (iclass_o != CL_NONE);
    assign shift_o = (funct_i[5:3] == FUNCT_SHIFT_HI);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] per class.
// Ports: clock, reset_n; Opcode/Function_opcode (sampled at fetch completion),
// Zero, mem_ready in; memory strobes, IR/PC strobes, ALU control set,
// register-file controls, sticky illegal flag and debug state out.
module multicycle_ctrl
    import cpu_defs::*;
#(
    parameter logic [4:0] JAL_REG = 5'd31
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [OP_W-1:0]    Opcode,
    input  logic [FUNCT_W-1:0] Function_opcode,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [1:0]         pc_src,
    output logic [1:0]         ALUOp,
    output logic               ALUSrc,
    output logic               I_format,
    output logic               Sftmd,
    output logic               RegWrite,
    output logic               MemtoReg,
    output logic [1:0]         wreg_sel,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    // The link register is r31 by default; r0 cannot hold a return address
    if (JAL_REG == 5'd0) begin : g_jal_reg_check
        $error("multicycle_ctrl: JAL_REG must not be r0");
    end

    state_e               state_q, state_d;
    logic [OP_W-1:0]      opcode_q, opcode_d;
    logic [FUNCT_W-1:0]   funct_q, funct_d;
    iclass_e              iclass;
    logic                 legal;
    logic                 shift;

    instr_class_decode u_decode (
        .opcode_i (opcode_q),
        .funct_i  (funct_q),
        .iclass_o (iclass),
        .legal_o  (legal),
        .shift_o  (shift)
    );

    // State and latched instruction fields
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_FETCH;
            opcode_q <= '0;
            funct_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
        end
    end

    // Next state and per-state strobes
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        funct_d  = funct_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        pc_src   = PC_SRC_SEQ;
        ALUOp    = ALUOP_ADD;
        ALUSrc   = 1'b0;
        I_format = 1'b0;
        Sftmd    = 1'b0;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        wreg_sel = WREG_RT;
        illegal  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    opcode_d = Opcode;
                    funct_d  = Function_opcode;
                    IRWrite  = 1'b1;
                    PCWrite  = 1'b1;
                    pc_src   = PC_SRC_SEQ;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (iclass)
                    CL_RTYPE: begin
                        ALUOp   = ALUOP_FUNCT;
                        Sftmd   = shift;
                        state_d = ST_WB;
                    end
                    CL_JR: begin
                        ALUOp   = ALUOP_FUNCT;
                        PCWrite = 1'b1;
                        pc_src  = PC_SRC_REG;
                    end
                    CL_IALU: begin
                        ALUOp    = ALUOP_FUNCT;
                        ALUSrc   = 1'b1;
                        I_format = 1'b1;
                        state_d  = ST_WB;
                    end
                    CL_LW, CL_SW: begin
                        ALUOp   = ALUOP_ADD;
                        ALUSrc  = 1'b1;
                        state_d = ST_MEM;
                    end
                    CL_BEQ, CL_BNE: begin
                        ALUOp = ALUOP_BRANCH;
                        // Taken branch is the only same-cycle dependence in EXEC
                        if ((iclass == CL_BEQ) ? Zero : !Zero) begin
                            PCWrite = 1'b1;
                            pc_src  = PC_SRC_BRANCH;
                        end
                    end
                    CL_J: begin
                        PCWrite = 1'b1;
                        pc_src  = PC_SRC_JUMP;
                    end
                    CL_JAL: begin
                        PCWrite = 1'b1;
                        pc_src  = PC_SRC_JUMP;
                        state_d = ST_WB;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (iclass == CL_SW);
                if (mem_ready) begin
                    state_d = (iclass == CL_LW) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (iclass == CL_LW);
                case (iclass)
                    CL_RTYPE: wreg_sel = WREG_RD;
                    CL_JAL:   wreg_sel = WREG_JAL;
                    default:  wreg_sel = WREG_RT;
                endcase
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase

        // Reset forces the state to FETCH; keep its fetch request quiet until release
        if (!reset_n) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            pc_src   = PC_SRC_SEQ;
            ALUOp    = ALUOP_ADD;
            ALUSrc   = 1'b0;
            I_format = 1'b0;
            Sftmd    = 1'b0;
            RegWrite = 1'b0;
            MemtoReg = 1'b0;
            wreg_sel = WREG_RT;
            illegal  = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level model expands
// each instruction into its expected per-cycle trace; every cycle is compared.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       i_format;
        logic       sftmd;
        logic       reg_write;
        logic       mem_to_reg;
        logic [1:0] wreg_sel;
        logic       illegal;
    } outs_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic       zero;
        logic [2:0] st;
        outs_t      o;
    } cyc_t;

    logic       clock;
    logic       reset_n;
    logic [5:0] Opcode;
    logic [5:0] Function_opcode;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req, mem_we, IRWrite, PCWrite;
    logic [1:0] pc_src, ALUOp;
    logic       ALUSrc, I_format, Sftmd, RegWrite, MemtoReg;
    logic [1:0] wreg_sel;
    logic       illegal;
    logic [2:0] state;
    outs_t      obs;

    int vectors = 0;
    int miscompares = 0;
    cyc_t trace[$];

    multicycle_ctrl #(.JAL_REG(5'd31)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .Opcode          (Opcode),
        .Function_opcode (Function_opcode),
        .Zero            (Zero),
        .mem_ready       (mem_ready),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .IRWrite         (IRWrite),
        .PCWrite         (PCWrite),
        .pc_src          (pc_src),
        .ALUOp           (ALUOp),
        .ALUSrc          (ALUSrc),
        .I_format        (I_format),
        .Sftmd           (Sftmd),
        .RegWrite        (RegWrite),
        .MemtoReg        (MemtoReg),
        .wreg_sel        (wreg_sel),
        .illegal         (illegal),
        .state           (state)
    );

    assign obs = {mem_req, mem_we, IRWrite, PCWrite, pc_src, ALUOp, ALUSrc,
                  I_format, Sftmd, RegWrite, MemtoReg, wreg_sel, illegal};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of run, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [2:0] exp_st, input outs_t exp_o);
        vectors++;
        assert ({state, obs} === {exp_st, exp_o}) else begin
            miscompares++;
            $error("FAIL %s: observed state=%0d outs=%h, expected state=%0d outs=%h",
                   tag, state, obs, exp_st, exp_o);
        end
    endtask

    // One cycle: drive inputs after the falling edge, then compare
    task automatic apply(input cyc_t c, input string tag);
        @(negedge clock);
        Opcode          = c.op;
        Function_opcode = c.fn;
        mem_ready       = c.rdy;
        Zero            = c.zero;
        #1;
        check(tag, c.st, c.o);
    endtask

    // Instruction-level model: expands one instruction into its cycle trace
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fw, input int mw);
        cyc_t c;
        bit is_r, is_jr, is_i, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, legal;
        is_r   = (op == 6'h00) && (fn != 6'h08);
        is_jr  = (op == 6'h00) && (fn == 6'h08);
        is_i   = (op >= 6'h08) && (op <= 6'h0F);
        is_lw  = (op == 6'h23);
        is_sw  = (op == 6'h2B);
        is_beq = (op == 6'h04);
        is_bne = (op == 6'h05);
        is_j   = (op == 6'h02);
        is_jal = (op == 6'h03);
        legal  = is_r | is_jr | is_i | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;
        trace.delete();

        for (int i = 0; i <= fw; i++) begin
            c = '0;
            c.op   = (i == fw) ? op : 6'($urandom);
            c.fn   = (i == fw) ? fn : 6'($urandom);
            c.rdy  = (i == fw);
            c.zero = 1'($urandom);
            c.st   = 3'd0;
            c.o.mem_req  = 1'b1;
            c.o.ir_write = (i == fw);
            c.o.pc_write = (i == fw);
            trace.push_back(c);
        end

        c = '0;
        c.op = 6'($urandom); c.fn = 6'($urandom);
        c.rdy = 1'($urandom); c.zero = 1'($urandom);
        c.st = 3'd1;
        trace.push_back(c);
        if (!legal) return;

        c = '0;
        c.op = 6'($urandom); c.fn = 6'($urandom);
        c.rdy = 1'($urandom); c.zero = z;
        c.st = 3'd2;
        if (is_r || is_jr) begin
            c.o.alu_op = 2'b10;
            c.o.sftmd  = is_r && (fn < 6'd8);
            if (is_jr) begin c.o.pc_write = 1'b1; c.o.pc_src = 2'b11; end
        end
        if (is_i) begin c.o.alu_op = 2'b10; c.o.alu_src = 1'b1; c.o.i_format = 1'b1; end
        if (is_lw || is_sw) begin c.o.alu_op = 2'b00; c.o.alu_src = 1'b1; end
        if (is_beq || is_bne) begin
            c.o.alu_op = 2'b01;
            if ((is_beq && z) || (is_bne && !z)) begin c.o.pc_write = 1'b1; c.o.pc_src = 2'b01; end
        end
        if (is_j || is_jal) begin c.o.pc_write = 1'b1; c.o.pc_src = 2'b10; end
        trace.push_back(c);

        if (is_lw || is_sw) begin
            for (int i = 0; i <= mw; i++) begin
                c = '0;
                c.op = 6'($urandom); c.fn = 6'($urandom);
                c.rdy = (i == mw); c.zero = 1'($urandom);
                c.st = 3'd3;
                c.o.mem_req = 1'b1;
                c.o.mem_we  = is_sw;
                trace.push_back(c);
            end
        end

        if (is_r || is_i || is_lw || is_jal) begin
            c = '0;
            c.op = 6'($urandom); c.fn = 6'($urandom);
            c.rdy = 1'($urandom); c.zero = 1'($urandom);
            c.st = 3'd4;
            c.o.reg_write  = 1'b1;
            c.o.mem_to_reg = is_lw;
            c.o.wreg_sel   = is_r ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
            trace.push_back(c);
        end
    endtask

    task automatic run_trace(input string tag, input int n);
        for (int i = 0; i < n && i < trace.size(); i++)
            apply(trace[i], $sformatf("%s[%0d]", tag, i));
    endtask

    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int fw, input int mw);
        build(op, fn, z, fw, mw);
        run_trace(tag, trace.size());
    endtask

    initial begin
        outs_t idle;
        outs_t fetch_idle;
        outs_t trap_o;
        cyc_t  c;
        logic [5:0] op, fn;
        idle = '0;
        fetch_idle = '0;
        fetch_idle.mem_req = 1'b1;
        trap_o = '0;
        trap_o.illegal = 1'b1;

        reset_n = 1'b0; Opcode = '0; Function_opcode = '0; Zero = 1'b0; mem_ready = 1'b1;
        @(negedge clock); #1;
        check("reset", 3'd0, idle);
        @(negedge clock);
        reset_n = 1'b1; mem_ready = 1'b0;
        #1;
        check("post_reset", 3'd0, fetch_idle);

        run("add",       6'h00, 6'h20, 1'b0, 0, 0);
        run("lw_wait2",  6'h23, 6'($urandom), 1'b0, 0, 2);
        run("beq_z1",    6'h04, 6'($urandom), 1'b1, 0, 0);
        run("beq_z0",    6'h04, 6'($urandom), 1'b0, 0, 0);
        run("sll",       6'h00, 6'h00, 1'b0, 0, 0);
        run("jr",        6'h00, 6'h08, 1'b0, 0, 0);
        run("bne_z0",    6'h05, 6'($urandom), 1'b0, 0, 0);
        run("bne_z1",    6'h05, 6'($urandom), 1'b1, 0, 0);
        run("j",         6'h02, 6'($urandom), 1'b0, 0, 0);
        run("jal",       6'h03, 6'($urandom), 1'b0, 0, 0);
        run("sw",        6'h2B, 6'($urandom), 1'b0, 0, 0);
        run("addi",      6'h08, 6'($urandom), 1'b0, 0, 0);
        run("lui",       6'h0F, 6'($urandom), 1'b0, 0, 0);
        run("ori_fwait", 6'h0D, 6'($urandom), 1'b0, 3, 0);
        run("sw_wait1",  6'h2B, 6'($urandom), 1'b1, 1, 1);

        for (int n = 0; n < 150; n++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 8))
                0: op = 6'h00;
                1: op = 6'(8 + $urandom_range(0, 7));
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                5: op = 6'h05;
                6: op = 6'h02;
                7: op = 6'h03;
                default: begin op = 6'h00; fn = 6'h08; end
            endcase
            run($sformatf("rand%0d_op%02h_fn%02h", n, op, fn), op, fn, 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Reset while a store waits in MEM
        build(6'h2B, 6'($urandom), 1'b0, 0, 3);
        run_trace("sw_pre_reset", 4);
        @(negedge clock);
        mem_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        check("sw_mid_reset", 3'd0, idle);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("sw_after_reset", 3'd0, fetch_idle);
        run("add_after_reset", 6'h00, 6'h22, 1'b0, 0, 0);

        // Undecodable opcode traps and holds until reset
        run("illegal_op", 6'h3F, 6'($urandom), 1'b0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            c = '0;
            c.op = 6'($urandom); c.fn = 6'($urandom);
            c.rdy = 1'($urandom); c.zero = 1'($urandom);
            c.st = 3'd7;
            c.o = trap_o;
            apply(c, $sformatf("trap_hold[%0d]", i));
        end
        @(negedge clock);
        reset_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("trap_reset", 3'd0, idle);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("trap_release", 3'd0, fetch_idle);
        run("lw_after_trap", 6'h23, 6'($urandom), 1'b0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the CPU datapath. Latches the decoded opcode/funct of each fetched instruction and steps FETCH → DECODE → EXEC → MEM → WB as required by the instruction class. Per state, it drives the ALU control set (ALUOp, ALUSrc, I_format, Sftmd) plus PC, IR, register-file and memory strobes, so one ALU instance serves address, branch and arithmetic work. Sits between the instruction/data memory interface and the register file/ALU/PC logic.

## Interface
- Parameters:
- `JAL_REG`, default 5'd31: destination register index reported on `wreg_sel` for JAL.
- Ports:
- `clock` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `Opcode` input 6: instruction bits [31:26]; sampled only on the fetch-complete edge.
- `Function_opcode` input 6: instruction bits [5:0]; sampled with `Opcode`.
- `Zero` input 1: ALU compare result; valid during EXEC.
- `mem_ready` input 1: memory handshake acknowledge.
- `mem_req` output 1: memory request, for fetch, load or store.
- `mem_we` output 1: store qualifier for `mem_req`.
- `IRWrite` output 1: load the instruction register.
- `PCWrite` output 1: unconditional PC load.
- `pc_src` output 2: PC source; 00 = PC+4, 01 = branch target, 10 = jump target, 11 = register (jr).
- `ALUOp` output 2: ALU operation class.
- `ALUSrc` output 1: ALU operand B select; 1 = sign-extended immediate.
- `I_format` output 1: ALU immediate-class flag.
- `Sftmd` output 1: ALU shift-class flag.
- `RegWrite` output 1: register-file write enable.
- `MemtoReg` output 1: write-back data select; 1 = memory data.
- `wreg_sel` output 2: destination select; 00 = rt, 01 = rd, 10 = `JAL_REG`.
- `illegal` output 1: sticky flag for an undecodable instruction.
- `state` output 3: current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH:
  - `mem_req`=1, `mem_we`=0; hold until `mem_ready`=1.
  - On that edge: latch `Opcode` and `Function_opcode`, pulse `IRWrite`=1 and `PCWrite`=1 with `pc_src`=00, then go to DECODE.
- DECODE: one cycle, no strobes. Next state is EXEC if the latched opcode is legal, otherwise TRAP.
- Legal set: R-type (op 0), addi/addiu/slti/sltiu/andi/ori/xori/lui (op[5:3]=001), lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03.
- EXEC signal values:
  - R-type: `ALUOp`=10, `ALUSrc`=0, `I_format`=0. `Sftmd`=1 when funct[5:3]=000.
  - I-ALU: `ALUOp`=10, `ALUSrc`=1, `I_format`=1.
  - lw/sw: `ALUOp`=00, `ALUSrc`=1.
  - beq/bne: `ALUOp`=01, `ALUSrc`=0. `PCWrite`=1 with `pc_src`=01 iff (beq & `Zero`) | (bne & !`Zero`).
  - j: `PCWrite`=1, `pc_src`=10.
  - jr (R-type, funct 0x08): `PCWrite`=1, `pc_src`=11, no write-back.
- Next state after EXEC:
  - lw/sw go to MEM.
  - R-type except jr, I-ALU and jal go to WB.
  - All others go to FETCH.
- jal in EXEC: `PCWrite`=1, `pc_src`=10.
- MEM: `mem_req`=1, `mem_we`=1 for sw; hold until `mem_ready`. Then lw goes to WB and sw goes to FETCH.
- WB: `RegWrite`=1 for exactly one cycle, then FETCH.
  - `MemtoReg`=1 only for lw.
  - `wreg_sel`: 01 for R-type, 00 for I-ALU and lw, 10 for jal.
- TRAP: `illegal`=1, all strobes 0, remains in TRAP until reset.
- Encoding: one-hot-free binary; unused state codes 5 and 6 go to FETCH.

## Timing
- During or after reset: state=FETCH, latched fields=0, `illegal`=0.
- All strobes are Moore outputs of state plus latched fields, except these, which also depend on same-cycle inputs:
  - `IRWrite` and `PCWrite` in FETCH (`mem_ready`).
  - branch `PCWrite` (`Zero`).
- `mem_req` stays high continuously until the acknowledging edge. `mem_ready` is ignored while `mem_req`=0.
- Cycle counts with zero-wait memory: R/I-ALU 4, lw 5, sw 4, beq/bne 3, j/jr 3, jal 4.
- Each wait cycle with `mem_ready`=0 adds one cycle in FETCH or MEM. Outputs stay stable throughout the wait.
- Reset asserted mid-instruction: all strobes drop to 0 asynchronously, including any pending `RegWrite` or `mem_we`. After release, execution restarts in FETCH.
- `Opcode` and `Function_opcode` changing outside the fetch-complete edge have no effect.

## Structure
- Shared package `cpu_defs`:
  - state encodings;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL);
  - FUNCT_JR;
  - ALUOp and `pc_src` encodings.
- One sub-module, `instr_class_decode`: combinational mapping of the latched opcode/funct to a class plus a legal flag. The FSM and output logic stay in `multicycle_ctrl`.

## Test plan
- Reset, then R-type add (op 0, funct 0x20) with `mem_ready` tied 1:
  - states 0,1,2,4,0;
  - EXEC has `ALUOp`=10, `Sftmd`=0;
  - WB has `RegWrite`=1, `wreg_sel`=01, `MemtoReg`=0.
- lw (0x23) with 2 wait cycles in MEM:
  - `mem_req`=1 held 3 cycles with `mem_we`=0;
  - then WB with `MemtoReg`=1, `wreg_sel`=00;
  - 7 cycles total.
- beq (0x04):
  - with `Zero`=1: one `PCWrite` pulse, `pc_src`=01;
  - with `Zero`=0: no EXEC `PCWrite`;
  - either case returns to FETCH after 3 cycles.
- sll (funct 0x00): `Sftmd`=1. jr (funct 0x08): `pc_src`=11, no WB state.
- Opcode 0x3F:
  - TRAP after DECODE;
  - `illegal`=1 and stays set for 20 cycles;
  - `reset_n` low clears it to FETCH.
- Assert `reset_n`=0 during a sw MEM cycle:
  - `mem_we` and `mem_req` drop to 0 before the next edge;
  - after release, FETCH with `mem_req`=1.
